// File: rtl/hilo_sequencer.sv
// HiLo register sequencer: paces multiply/accumulate commits and register moves into Hi/Lo.
// Optional multiply-accumulate (MADD/MSUB) support is enabled by defining HILO_SEQ_ACCUM_EN.
module hilo_sequencer #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic       OpValid_i,
  input  logic [2:0] OpCode_i,
  input  logic       Flush_i,
  output logic       Stall_o,
  output logic       HiLoALUControl_o,
  output logic       AddToHi_o,
  output logic       AddToLo_o,
  output logic       AccumSub_o,
  output logic       MoveToHi_o,
  output logic       MoveToLo_o,
  output logic       HiLoSel_o,
  output logic       Busy_o,
  output logic       Done_o,
  output logic       IllegalOp_o
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, COMMIT} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_MULT, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO
  } op_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  op_e        op_q, op_d;
  logic       alu_q, alu_d;
  logic       done_q, done_d;
  logic       mthi_q, mthi_d;
  logic       mtlo_q, mtlo_d;
  logic       sel_q, sel_d;
  logic       ill_q, ill_d;
`ifdef HILO_SEQ_ACCUM_EN
  logic       acc_q, acc_d;
  logic       sub_q, sub_d;
`endif

  logic busy, accept, is_mul, is_acc, start, illegal;
  op_e  op_in;

  assign op_in  = op_e'(OpCode_i);
  assign busy   = (state_q != IDLE);
  assign accept = OpValid_i && !busy && !Flush_i && !Reset_i;
  assign is_mul = (op_in == OP_MULT);
  assign is_acc = (op_in == OP_MADD) || (op_in == OP_MSUB);

`ifdef HILO_SEQ_ACCUM_EN
  assign start   = accept && (is_mul || is_acc);
  assign illegal = 1'b0;
`else
  // Accumulate ops are consumed without effect other than the IllegalOp pulse.
  assign start   = accept && is_mul;
  assign illegal = accept && is_acc;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    alu_d   = 1'b0;
    done_d  = 1'b0;
    mthi_d  = accept && (op_in == OP_MTHI);
    mtlo_d  = accept && (op_in == OP_MTLO);
    ill_d   = illegal;
    sel_d   = sel_q;
`ifdef HILO_SEQ_ACCUM_EN
    acc_d   = 1'b0;
    sub_d   = 1'b0;
`endif
    if (accept && (op_in == OP_MFHI)) begin
      sel_d = 1'b1;
    end else if (accept && (op_in == OP_MFLO)) begin
      sel_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MUL_WAIT;
          cnt_d   = CNT_INIT;
          op_d    = op_in;
        end
      end
      MUL_WAIT: begin
        if (Flush_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          op_d    = OP_NOP;
        end else if (cnt_q == 4'd0) begin
          // Strobes are computed one cycle early so they leave a flop in COMMIT.
          state_d = COMMIT;
          alu_d   = (op_q == OP_MULT);
          done_d  = 1'b1;
`ifdef HILO_SEQ_ACCUM_EN
          acc_d   = (op_q == OP_MADD) || (op_q == OP_MSUB);
          sub_d   = (op_q == OP_MSUB);
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        op_d    = OP_NOP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= OP_NOP;
      alu_q   <= 1'b0;
      done_q  <= 1'b0;
      mthi_q  <= 1'b0;
      mtlo_q  <= 1'b0;
      sel_q   <= 1'b0;
      ill_q   <= 1'b0;
`ifdef HILO_SEQ_ACCUM_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      alu_q   <= alu_d;
      done_q  <= done_d;
      mthi_q  <= mthi_d;
      mtlo_q  <= mtlo_d;
      sel_q   <= sel_d;
      ill_q   <= ill_d;
`ifdef HILO_SEQ_ACCUM_EN
      acc_q   <= acc_d;
      sub_q   <= sub_d;
`endif
    end
  end

  assign Stall_o          = OpValid_i && busy;
  assign Busy_o           = busy;
  assign HiLoALUControl_o = alu_q;
  assign Done_o           = done_q;
  assign MoveToHi_o       = mthi_q;
  assign MoveToLo_o       = mtlo_q;
  assign HiLoSel_o        = sel_q;
  assign IllegalOp_o      = ill_q;
`ifdef HILO_SEQ_ACCUM_EN
  assign AddToHi_o        = acc_q;
  assign AddToLo_o        = acc_q;
  assign AccumSub_o       = sub_q;
`else
  assign AddToHi_o        = 1'b0;
  assign AddToLo_o        = 1'b0;
  assign AccumSub_o       = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed, table-driven bench for hilo_sequencer at MUL_LATENCY=4.
// Output vector order: {Stall, ALU, AddHi, AddLo, Sub, MvHi, MvLo, Sel, Busy, Done, Illegal}.
module tb_hilo_sequencer;

  localparam int unsigned LAT = 4;
  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MADD = 3'd2, MSUB = 3'd3,
                         MTHI = 3'd4, MTLO = 3'd5, MFHI = 3'd6, MFLO = 3'd7;

  logic       clk = 1'b0;
  logic       rst, vld, fl;
  logic [2:0] op;
  logic       Stall, AluCtl, AddHi, AddLo, Sub, MvHi, MvLo, Sel, Busy, Done, Ill;

  hilo_sequencer #(.MUL_LATENCY(LAT)) dut (
    .Clk_i(clk), .Reset_i(rst), .OpValid_i(vld), .OpCode_i(op), .Flush_i(fl),
    .Stall_o(Stall), .HiLoALUControl_o(AluCtl), .AddToHi_o(AddHi), .AddToLo_o(AddLo),
    .AccumSub_o(Sub), .MoveToHi_o(MvHi), .MoveToLo_o(MvLo), .HiLoSel_o(Sel),
    .Busy_o(Busy), .Done_o(Done), .IllegalOp_o(Ill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [2:0]  op;
    logic        fl;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nfail = 0;

  task automatic add(input logic r, input logic v, input logic [2:0] o, input logic f,
                     input logic [10:0] e);
    vec_t t;
    t.rst = r; t.vld = v; t.op = o; t.fl = f; t.exp = e;
    tbl.push_back(t);
  endtask

  // One cycle: drive inputs just after the edge, then check that cycle's outputs.
  task automatic step(input logic r, input logic v, input logic [2:0] o, input logic f,
                      input logic [10:0] e, input string nm);
    logic [10:0] obs;
    @(posedge clk);
    #1;
    rst = r; vld = v; op = o; fl = f;
    #1;
    obs = {Stall, AluCtl, AddHi, AddLo, Sub, MvHi, MvLo, Sel, Busy, Done, Ill};
    nvec++;
    if (obs !== e) begin
      nfail++;
      $display("FAIL %s: got %b expected %b", nm, obs, e);
    end
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; op = NOP; fl = 1'b0;

    add(1, 0, NOP,  0, 11'b0_0000_00_0_000);  // reset state
    // MTHI then MTLO back to back
    add(0, 1, MTHI, 0, 11'b0_0000_00_0_000);
    add(0, 1, MTLO, 0, 11'b0_0000_10_0_000);
    add(0, 0, NOP,  0, 11'b0_0000_01_0_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_0_000);
    // MFHI / MFLO select and hold
    add(0, 1, MFHI, 0, 11'b0_0000_00_0_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_000);
    add(0, 1, NOP,  0, 11'b0_0000_00_1_000);
    add(0, 1, MFLO, 0, 11'b0_0000_00_1_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_0_000);
    // Flush in IDLE discards the op
    add(0, 1, MFHI, 1, 11'b0_0000_00_0_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_0_000);
    // MULT with MFHI held from N+2: stall through COMMIT, accepted at N+6
    add(0, 1, MULT, 0, 11'b0_0000_00_0_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_0_100);
    add(0, 1, MFHI, 0, 11'b1_0000_00_0_100);
    add(0, 1, MFHI, 0, 11'b1_0000_00_0_100);
    add(0, 1, MFHI, 0, 11'b1_0000_00_0_100);
    add(0, 1, MFHI, 0, 11'b1_1000_00_0_110);
    add(0, 1, MFHI, 0, 11'b0_0000_00_0_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_000);
    // Flush in MUL_WAIT: no commit
    add(0, 1, MULT, 0, 11'b0_0000_00_1_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_100);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_100);
    add(0, 0, NOP,  1, 11'b0_0000_00_1_100);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_000);
    // Flush during COMMIT is ignored
    add(0, 1, MULT, 0, 11'b0_0000_00_1_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_100);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_100);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_100);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_100);
    add(0, 0, NOP,  1, 11'b0_1000_00_1_110);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_000);
    // Reset mid-multiply, then a fresh MULT commits LAT+1 cycles later
    add(0, 1, MULT, 0, 11'b0_0000_00_1_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_1_100);
    add(1, 1, MTHI, 0, 11'b1_0000_00_1_100);
    add(0, 1, MULT, 0, 11'b0_0000_00_0_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_0_100);
    add(0, 0, NOP,  0, 11'b0_0000_00_0_100);
    add(0, 0, NOP,  0, 11'b0_0000_00_0_100);
    add(0, 0, NOP,  0, 11'b0_0000_00_0_100);
    add(0, 0, NOP,  0, 11'b0_1000_00_0_110);
    add(0, 0, NOP,  0, 11'b0_0000_00_0_000);
    // Reset overrides a valid MFHI
    add(1, 1, MFHI, 0, 11'b0_0000_00_0_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_0_000);
    // Repeated MTHI pulses every cycle without stalling
    add(0, 1, MTHI, 0, 11'b0_0000_00_0_000);
    add(0, 1, MTHI, 0, 11'b0_0000_10_0_000);
    add(0, 0, NOP,  0, 11'b0_0000_10_0_000);
    add(0, 0, NOP,  0, 11'b0_0000_00_0_000);

    // Prelude reset cycle so outputs are defined before the first check.
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].op, tbl[i].fl, tbl[i].exp, $sformatf("vec%0d", i));
    end

`ifdef HILO_SEQ_ACCUM_EN
    // MSUB: accumulate-subtract strobes only in the COMMIT cycle
    step(0, 1, MSUB, 0, 11'b0_0000_00_0_000, "msub_accept");
    for (int c = 1; c <= 4; c++) step(0, 0, NOP, 0, 11'b0_0000_00_0_100, "msub_wait");
    step(0, 0, NOP, 0, 11'b0_0111_00_0_110, "msub_commit");
    step(0, 0, NOP, 0, 11'b0_0000_00_0_000, "msub_idle");
    // MADD flushed at cycle 3
    step(0, 1, MADD, 0, 11'b0_0000_00_0_000, "madd_fl_accept");
    step(0, 0, NOP,  0, 11'b0_0000_00_0_100, "madd_fl_c1");
    step(0, 0, NOP,  0, 11'b0_0000_00_0_100, "madd_fl_c2");
    step(0, 0, NOP,  1, 11'b0_0000_00_0_100, "madd_fl_c3");
    for (int c = 4; c <= 6; c++) step(0, 0, NOP, 0, 11'b0_0000_00_0_000, "madd_fl_after");
    // MADD with flush in COMMIT still commits as an add
    step(0, 1, MADD, 0, 11'b0_0000_00_0_000, "madd_accept");
    for (int c = 1; c <= 4; c++) step(0, 0, NOP, 0, 11'b0_0000_00_0_100, "madd_wait");
    step(0, 0, NOP, 1, 11'b0_0110_00_0_110, "madd_commit_flush");
    step(0, 0, NOP, 0, 11'b0_0000_00_0_000, "madd_idle");
`else
    // Without accumulate support: MSUB/MADD only pulse IllegalOp, never Busy
    step(0, 1, MSUB, 0, 11'b0_0000_00_0_000, "msub_ill_c0");
    step(0, 0, NOP,  0, 11'b0_0000_00_0_001, "msub_ill_c1");
    for (int c = 2; c <= 6; c++) step(0, 0, NOP, 0, 11'b0_0000_00_0_000, "msub_ill_after");
    step(0, 1, MADD, 0, 11'b0_0000_00_0_000, "madd_ill_c0");
    step(0, 1, MADD, 0, 11'b0_0000_00_0_001, "madd_ill_c1");
    step(0, 1, MADD, 1, 11'b0_0000_00_0_001, "madd_ill_c2");
    step(0, 0, NOP,  0, 11'b0_0000_00_0_000, "madd_ill_flushed");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
